// File: rtl/ifu_prefetch_queue_pkg.sv
// Shared definitions for the instruction-fetch prefetch queue: address map defaults,
// queue entry layout and the fetch-address fault check.
package ifu_prefetch_queue_pkg;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
   localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;
   localparam logic [31:0] DEF_PC_LO    = 32'h0000_3000;
   localparam logic [31:0] DEF_PC_HI    = 32'h0000_6ffc;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } fetch_entry_t;

   // Misaligned or outside the legal fetch window (unsigned compare).
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
      return (addr[1:0] != 2'b00) || (addr < lo) || (addr > hi);
   endfunction

endpackage

// File: rtl/ifu_prefetch_queue_fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush; push and pop may coincide
// at any occupancy, including full.
module ifu_prefetch_queue_fetch_fifo
   import ifu_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   CLK,
   input  logic                   Reset,
   input  logic                   push,
   input  fetch_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output fetch_entry_t           head,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t  mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          pop_s;
   logic          push_s;

   // A push into a full FIFO is only legal when the head leaves in the same cycle.
   always_comb begin
      pop_s  = pop && (count_r != {CW{1'b0}});
      push_s = push && ((count_r != CW'(DEPTH)) || pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '{pc: 32'h0, inst: 32'h0, adel: 1'b0};
         end
      end else if (flush) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
            wr_ptr_r        <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = mem_r[rd_ptr_r];
   assign count = count_r;

endmodule

// File: rtl/ifu_prefetch_queue.sv
// Instruction-fetch unit: owns the fetch PC, issues in-order imem requests under a credit
// limit, buffers returned words in a prefetch queue and discards responses made stale by redirects.
module ifu_prefetch_queue
   import ifu_prefetch_queue_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEF_RESET_PC,
   parameter logic [31:0] EXC_PC   = DEF_EXC_PC,
   parameter logic [31:0] PC_LO    = DEF_PC_LO,
   parameter logic [31:0] PC_HI    = DEF_PC_HI,
   parameter int          DEPTH    = 4
) (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   input  logic        br_valid,
   input  logic [31:0] br_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic        id_adel
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]  pc_r;
   logic [31:0]  resp_pc_r;
   logic [CW-1:0] out_cnt_r;
   logic [CW-1:0] drop_cnt_r;
   logic         fault_stall_r;

   logic         redirect_s;
   logic [31:0]  target_s;
   logic         pc_fault_s;
   logic [CW:0]  used_s;
   logic         credit_ok_s;
   logic         issue_s;
   logic         resp_keep_s;
   logic         fault_push_s;
   logic         push_s;
   fetch_entry_t push_data_s;
   fetch_entry_t head_s;
   logic [CW-1:0] fifo_count_s;

   // Redirect arbitration and issue/enqueue decisions.
   always_comb begin
      redirect_s = exc_req || eret_req || br_valid;
      if (exc_req) begin
         target_s = EXC_PC;
      end else if (eret_req) begin
         target_s = epc;
      end else begin
         target_s = br_target;
      end
      pc_fault_s  = addr_fault(pc_r, PC_LO, PC_HI);
      used_s      = {1'b0, fifo_count_s} + {1'b0, out_cnt_r};
      credit_ok_s = used_s < (CW+1)'(DEPTH);
      imem_req    = !Reset && !redirect_s && credit_ok_s && !pc_fault_s && !fault_stall_r;
      issue_s     = imem_req && imem_gnt;
      resp_keep_s = imem_rvalid && (drop_cnt_r == {CW{1'b0}}) && !redirect_s && !Reset;
      // The fault entry waits for every in-flight word so it lands behind them in order.
      fault_push_s = !Reset && !redirect_s && pc_fault_s && !fault_stall_r &&
                     (out_cnt_r == {CW{1'b0}}) && (fifo_count_s != CW'(DEPTH));
      push_s = resp_keep_s || fault_push_s;
      if (fault_push_s) begin
         push_data_s = '{pc: pc_r, inst: 32'h0, adel: 1'b1};
      end else begin
         push_data_s = '{pc: resp_pc_r, inst: imem_rdata, adel: 1'b0};
      end
   end

   // Fetch PC, credit, drop and fault-stall state.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         pc_r          <= RESET_PC;
         resp_pc_r     <= RESET_PC;
         out_cnt_r     <= {CW{1'b0}};
         drop_cnt_r    <= {CW{1'b0}};
         fault_stall_r <= 1'b0;
      end else if (redirect_s) begin
         pc_r          <= target_s;
         resp_pc_r     <= target_s;
         out_cnt_r     <= out_cnt_r - CW'(imem_rvalid);
         drop_cnt_r    <= out_cnt_r - CW'(imem_rvalid);
         fault_stall_r <= 1'b0;
      end else begin
         if (issue_s) begin
            pc_r <= pc_r + 32'd4;
         end
         if (resp_keep_s) begin
            resp_pc_r <= resp_pc_r + 32'd4;
         end
         case ({issue_s, imem_rvalid})
            2'b10:   out_cnt_r <= out_cnt_r + CW'(1);
            2'b01:   out_cnt_r <= out_cnt_r - CW'(1);
            default: out_cnt_r <= out_cnt_r;
         endcase
         if (imem_rvalid && (drop_cnt_r != {CW{1'b0}})) begin
            drop_cnt_r <= drop_cnt_r - CW'(1);
         end
         if (fault_push_s) begin
            fault_stall_r <= 1'b1;
         end
      end
   end

   ifu_prefetch_queue_fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .CLK       (CLK),
      .Reset     (Reset),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (id_ready),
      .flush     (redirect_s),
      .head      (head_s),
      .count     (fifo_count_s)
   );

   assign imem_addr = pc_r;
   assign id_valid  = (fifo_count_s != {CW{1'b0}});
   assign id_pc     = id_valid ? head_s.pc   : 32'h0;
   assign id_inst   = id_valid ? head_s.inst : 32'h0;
   assign id_adel   = id_valid ? head_s.adel : 1'b0;

endmodule
